// File: rtl/uart_tx_buf_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : uart_tx_buf_if                                       |
// | Description : Write-side bundle for uart_tx_buf: byte push strobe,  |
// |               data and FIFO status flags.                          |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
interface uart_tx_buf_if #(
  parameter int D_WIDTH = 8,
  parameter int FIFO_AW = 3
);
  logic               wr_en;
  logic [D_WIDTH-1:0] wr_data;
  logic               full;
  logic               empty;
  logic [FIFO_AW:0]   count;
  logic               overflow;

  // Producer side (controller read-data path)
  modport master (
    output wr_en, wr_data,
    input  full, empty, count, overflow
  );

  // Transmitter side
  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : uart_tx_buf                                          |
// | Description : UART transmitter fed by a small synchronous FIFO.    |
// |               Frame = start, D_WIDTH data bits LSB first, stop;    |
// |               frames run back-to-back while the FIFO holds data.   |
// |               Define UART_TX_PARITY_EN to insert an even-parity    |
// |               bit between the last data bit and the stop bit.      |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module uart_tx_buf #(
  parameter int CLK_FREQ  = 133_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int D_WIDTH   = 8,
  parameter int FIFO_AW   = 3
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  uart_tx_buf_if.slave       wr_if,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int DEPTH        = 1 << FIFO_AW;
  localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE - 1;
  localparam int CNT_W        = (BAUD_CNT_MAX > 0) ? $clog2(BAUD_CNT_MAX + 1) : 1;
  localparam int IDX_W        = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_CNT_MAX);
  // Second-to-last count of a bit; only meaningful when a bit spans >1 cycle
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'((BAUD_CNT_MAX > 0) ? BAUD_CNT_MAX - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(D_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // ------------------------------------------------------------------
  // FIFO storage and pointers
  // ------------------------------------------------------------------
  logic [D_WIDTH-1:0] r_mem [DEPTH];
  logic [FIFO_AW:0]   r_wr_ptr;
  logic [FIFO_AW:0]   r_rd_ptr;
  logic               r_overflow;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [D_WIDTH-1:0] w_head;

  // ------------------------------------------------------------------
  // Transmit state
  // ------------------------------------------------------------------
  state_t             r_state;
  logic [CNT_W-1:0]   r_baud_cnt;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [D_WIDTH-1:0] r_shift;
  logic               w_baud_last;
  logic [D_WIDTH-1:0] w_shift_next;
`ifdef UART_TX_PARITY_EN
  logic               r_parity;
`endif

  assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  // A write while full is dropped even if a pop frees a slot this cycle
  assign w_push  = wr_if.wr_en && !w_full;
  assign w_head  = r_mem[r_rd_ptr[FIFO_AW-1:0]];

  assign w_baud_last  = (r_baud_cnt == CNT_LAST);
  assign w_shift_next = r_shift >> 1;
  // Pop on the idle edge, or on the last stop-bit cycle to chain frames
  assign w_pop = !w_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last));

  assign wr_if.full     = w_full;
  assign wr_if.empty    = w_empty;
  assign wr_if.count    = r_wr_ptr - r_rd_ptr;
  assign wr_if.overflow = r_overflow;

  // FIFO data array; contents need no reset since pointers gate validity
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[FIFO_AW-1:0]] <= wr_if.wr_data;
    end
  end

  // FIFO pointers and the dropped-write pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_if.wr_en && w_full;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Frame sequencer: baud timing, shifting and all registered serial outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= '0;
          if (!w_empty) begin
            r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_head;
`endif
            r_state <= S_START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end

        S_START: begin
          if (w_baud_last) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_state    <= S_DATA;
            tx         <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_baud_last) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              tx      <= r_parity;
`else
              r_state <= S_STOP;
              tx      <= 1'b1;
              // Single-cycle bits: the stop bit's only cycle is also its last
              tx_done <= (BAUD_CNT_MAX == 0);
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= w_shift_next;
              tx        <= w_shift_next[0];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_last) begin
            r_baud_cnt <= '0;
            r_state    <= S_STOP;
            tx         <= 1'b1;
            tx_done    <= (BAUD_CNT_MAX == 0);
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (w_baud_last) begin
            r_baud_cnt <= '0;
            if (!w_empty) begin
              r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
              r_parity <= ^w_head;
`endif
              r_state <= S_START;
              tx      <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              tx_busy <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
            // Registered pulse lands on the final stop-bit cycle
            if (r_baud_cnt == CNT_PENULT) begin
              tx_done <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_uart_tx_buf                                       |
// | Description : Self-checking bench for uart_tx_buf. Scaled baud      |
// |               (10 cycles per bit) keeps frames short.              |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_uart_tx_buf;

  localparam int CLK_FREQ  = 100;
  localparam int BAUD_RATE = 10;
  localparam int BIT       = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic tx, tx_busy, tx_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];

  uart_tx_buf_if #(.D_WIDTH(8), .FIFO_AW(3)) wr_if ();

  uart_tx_buf #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .D_WIDTH  (8),
    .FIFO_AW  (3)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .wr_if    (wr_if),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Polls for the start-bit edge; leaves the bench on the first low cycle
  task automatic wait_start(input int limit, output logic found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Bench receiver: samples every cycle of a frame, checks each level is
  // held BIT cycles and that tx_done appears only on the final cycle.
  task automatic recv_frame(output logic [7:0] data, output logic par,
                            output logic frame_ok, output logic done_ok);
    logic [FRAME_BITS-1:0] bits;
    bits = '0;
    frame_ok = 1'b1;
    done_ok = 1'b1;
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int k = 0; k < BIT; k++) begin
        if (k == 0) bits[b] = tx;
        else if (tx !== bits[b]) frame_ok = 1'b0;
        if (tx_done !== ((b == FRAME_BITS - 1) && (k == BIT - 1))) done_ok = 1'b0;
        tick();
      end
    end
    if (bits[0] !== 1'b0 || bits[FRAME_BITS-1] !== 1'b1) frame_ok = 1'b0;
    data = bits[8:1];
    par  = bits[FRAME_BITS-2];
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    wr_if.wr_en = 1'b0;
    wr_if.wr_data = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({tx, tx_busy, tx_done, wr_if.overflow, wr_if.full, wr_if.empty, wr_if.count}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
        n_bad++;
        $display("FAIL reset_state cyc%0d: got tx=%b busy=%b done=%b ovf=%b full=%b empty=%b count=%0d want 1 0 0 0 0 1 0",
                 i, tx, tx_busy, tx_done, wr_if.overflow, wr_if.full, wr_if.empty, wr_if.count);
      end
    end
    sys_rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_single();
    logic [7:0] got, want;
    logic par, fok, dok;
    wr_if.wr_en = 1'b1;
    wr_if.wr_data = 8'h44;
    exp_q.push_back(8'h44);
    tick();
    wr_if.wr_en = 1'b0;
    wr_if.wr_data = 8'hFF;
    n_cmp++;
    if ({wr_if.empty, tx} !== 2'b01) begin
      n_bad++;
      $display("FAIL single_after_wr: got empty=%b tx=%b want empty=0 tx=1", wr_if.empty, tx);
    end
    tick();
    n_cmp++;
    if ({tx, tx_busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL single_latency: got tx=%b busy=%b want tx=0 busy=1", tx, tx_busy);
    end
    recv_frame(got, par, fok, dok);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL single_data: got %h want %h", got, want);
    end
    n_cmp++;
    if ({fok, dok} !== 2'b11) begin
      n_bad++;
      $display("FAIL single_timing: got frame_ok=%b done_ok=%b want 1 1", fok, dok);
    end
    n_cmp++;
    if ({tx_busy, wr_if.empty, tx} !== 3'b011) begin
      n_bad++;
      $display("FAIL single_idle: got busy=%b empty=%b tx=%b want 0 1 1", tx_busy, wr_if.empty, tx);
    end
  endtask

  task automatic test_back_to_back();
    fork
      begin : writer
        for (int i = 1; i <= 10; i++) begin
          wr_if.wr_en = 1'b1;
          wr_if.wr_data = 8'(i);
          if (i <= 9) exp_q.push_back(8'(i));
          tick();
          if (i == 2) begin
            n_cmp++;
            if (tx !== 1'b0) begin
              n_bad++;
              $display("FAIL b2b_first_pop: got tx=%b want 0", tx);
            end
          end
          if (i == 9) begin
            n_cmp++;
            if ({wr_if.full, wr_if.overflow, wr_if.count} !== {1'b1, 1'b0, 4'd8}) begin
              n_bad++;
              $display("FAIL b2b_full: got full=%b ovf=%b count=%0d want 1 0 8",
                       wr_if.full, wr_if.overflow, wr_if.count);
            end
          end
          if (i == 10) begin
            n_cmp++;
            if ({wr_if.full, wr_if.overflow, wr_if.count} !== {1'b1, 1'b1, 4'd8}) begin
              n_bad++;
              $display("FAIL b2b_overflow: got full=%b ovf=%b count=%0d want 1 1 8",
                       wr_if.full, wr_if.overflow, wr_if.count);
            end
          end
        end
        wr_if.wr_en = 1'b0;
        tick();
        n_cmp++;
        if (wr_if.overflow !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_ovf_pulse: got ovf=%b want 0", wr_if.overflow);
        end
      end
      begin : receiver
        logic found, par, fok, dok;
        logic [7:0] got, want;
        wait_start(20, found);
        n_cmp++;
        if (found !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_start: got found=%b want 1", found);
        end
        for (int f = 0; f < 9; f++) begin
          if (f > 0) begin
            n_cmp++;
            if (tx !== 1'b0) begin
              n_bad++;
              $display("FAIL b2b_gap frame%0d: got tx=%b want 0", f, tx);
            end
          end
          recv_frame(got, par, fok, dok);
          want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          n_cmp++;
          if ({got, fok, dok} !== {want, 2'b11}) begin
            n_bad++;
            $display("FAIL b2b_frame%0d: got data=%h ok=%b%b want data=%h ok=11", f, got, fok, dok, want);
          end
        end
        n_cmp++;
        if ({wr_if.count, tx_busy, tx} !== {4'd0, 1'b0, 1'b1}) begin
          n_bad++;
          $display("FAIL b2b_drain: got count=%0d busy=%b tx=%b want 0 0 1", wr_if.count, tx_busy, tx);
        end
      end
    join
  endtask

  task automatic test_wrap();
    logic found, par, fok, dok;
    logic [7:0] got, want, b;
    for (int j = 0; j < 20; j++) begin
      b = 8'(8'h30 + j * 7);
      wr_if.wr_en = 1'b1;
      wr_if.wr_data = b;
      exp_q.push_back(b);
      tick();
      wr_if.wr_en = 1'b0;
      wr_if.wr_data = ~b;
      wait_start(5, found);
      if (found !== 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wrap_start%0d: got found=0 want 1", j);
        exp_q.delete();
        return;
      end
      recv_frame(got, par, fok, dok);
      want = exp_q.pop_front();
      n_cmp++;
      if ({got, fok, dok} !== {want, 2'b11}) begin
        n_bad++;
        $display("FAIL wrap_frame%0d: got data=%h ok=%b%b want data=%h ok=11", j, got, fok, dok, want);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic found;
    int bad_cycles;
    wr_if.wr_en = 1'b1;
    wr_if.wr_data = 8'hA5;
    tick();
    wr_if.wr_en = 1'b0;
    wait_start(5, found);
    for (int i = 0; i < BIT * 4 + 2; i++) tick();
    n_cmp++;
    if ({found, tx} !== 2'b10) begin
      n_bad++;
      $display("FAIL midrst_bit3: got found=%b tx=%b want 1 0", found, tx);
    end
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx, tx_busy, wr_if.empty, wr_if.count} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
      n_bad++;
      $display("FAIL midrst_async: got tx=%b busy=%b empty=%b count=%0d want 1 0 1 0",
               tx, tx_busy, wr_if.empty, wr_if.count);
    end
    exp_q.delete();
    tick();
    tick();
    sys_rst_n = 1'b1;
    bad_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++;
      $display("FAIL midrst_quiet: got %0d active cycles want 0", bad_cycles);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic found, par, fok, dok;
    logic [7:0] got, want, b;
    for (int j = 0; j < 2; j++) begin
      b = (j == 0) ? 8'h55 : 8'h54;
      wr_if.wr_en = 1'b1;
      wr_if.wr_data = b;
      exp_q.push_back(b);
      tick();
      wr_if.wr_en = 1'b0;
      wait_start(5, found);
      recv_frame(got, par, fok, dok);
      want = exp_q.pop_front();
      n_cmp++;
      if ({found, got, par, fok, dok} !== {1'b1, want, ^want, 2'b11}) begin
        n_bad++;
        $display("FAIL parity%0d: got data=%h par=%b ok=%b%b want data=%h par=%b ok=11",
                 j, got, par, fok, dok, want, ^want);
      end
    end
  endtask
`endif

  initial begin
    wr_if.wr_en = 1'b0;
    wr_if.wr_data = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
- UART transmitter with a small input FIFO. It is the transmit-side counterpart of uart_rx.
- Takes parallel bytes (SDRAM read data / status from the command path) and serialises them onto uart_tx.
- Frame format: start bit, D_WIDTH data bits LSB first, stop bit. Frames are sent back-to-back while the FIFO holds data.
- Sits between the controller read-data path and the top-level uart_tx pin; uart_tx_done is derived from tx_done.

Parameters:
- CLK_FREQ, 133_000_000, system clock frequency in Hz
- BAUD_RATE, 9600, serial bit rate
- D_WIDTH, 8, data bits per frame
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8

Ports:
- sys_clk  input  1  system clock
- sys_rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  push wr_data into FIFO (single-cycle strobe)
- wr_data  input  D_WIDTH  byte to transmit
- full  output  1  FIFO holds 2**FIFO_AW entries
- empty  output  1  FIFO holds 0 entries
- count  output  FIFO_AW+1  FIFO occupancy
- overflow  output  1  one-cycle pulse when wr_en is dropped because the FIFO is full
- tx  output  1  serial output, idle high
- tx_busy  output  1  high in any state other than IDLE
- tx_done  output  1  one-cycle pulse on the last cycle of each stop bit

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst_n is asynchronous and active-low.
- Reset values: tx=1, tx_busy=0, tx_done=0, overflow=0, full=0, empty=1, count=0; FIFO pointers and baud counter cleared; state IDLE.
- Reset mid-frame: tx returns to 1 immediately (asynchronous); FIFO contents are discarded.
- Baud timing:
  - BAUD_CNT_MAX = CLK_FREQ/BAUD_RATE - 1 (integer division; 13853 at defaults).
  - Every bit is held exactly BAUD_CNT_MAX+1 cycles.
  - Baud counter is 0 at the start of each bit and counts up to BAUD_CNT_MAX.
- FIFO:
  - Synchronous. Write pointer and read pointer are FIFO_AW+1 bits wide and wrap naturally.
  - full = (ptr MSBs differ) && (low bits equal). empty = (pointers equal).
  - A write is accepted when wr_en && !full.
  - A write while full is ignored, even if a pop occurs in the same cycle, and overflow pulses.
  - Simultaneous accepted write and pop leaves count unchanged.
- State machine (IDLE, START, DATA, STOP):
  - IDLE: if !empty at a clock edge: pop the head entry into the shift register, go to START, tx=0 from that edge.
  - START: after BAUD_CNT_MAX+1 cycles, go to DATA with bit index 0; tx = shift[0].
  - DATA: shift right at each bit end. After bit D_WIDTH-1, go to STOP with tx=1.
  - STOP: on the last cycle of the stop bit, assert tx_done for one cycle.
    - If !empty: pop and go directly to START. The next start bit begins on the following cycle, with no idle cycles between frames.
    - Otherwise return to IDLE.
- Latency: wr_en sampled at edge N with the FIFO empty and the FSM in IDLE → empty=0 after N → tx falls after edge N+1.
- Frame length: exactly (D_WIDTH+2)*(BAUD_CNT_MAX+1) cycles from tx falling to tx_done inclusive.
- wr_data is captured on write; later changes on wr_data do not affect queued bytes.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the data bits) is inserted between the last data bit and the stop bit. Frame is D_WIDTH+3 bits; FSM adds a PARITY state (DATA → PARITY → STOP).
- Undefined: no parity state, and the frame is D_WIDTH+2 bits.

Test Plan:
- Reset: assert sys_rst_n=0 for 5 cycles → tx=1, empty=1, full=0, count=0, tx_busy=0, tx_done=0 throughout.
- Single byte 8'h44 → tx falls 2 edges after wr_en. Serial sequence 0 | 0,0,1,0,0,0,1,0 | 1, each level held 13854 cycles. tx_done pulses once, 138540 cycles after tx falls; tx_busy=0 afterwards.
- Back-to-back: 10 writes on consecutive cycles (0x01..0x0A) → first byte popped immediately. full=1 after the 9th accepted write; the 10th is dropped with a one-cycle overflow pulse. Nine frames 0x01..0x09 are sent with the next start bit immediately following each stop bit; count returns to 0.
- Wrap-around: 20 single writes spaced one frame apart → all 20 bytes are received in order by a bench uart_rx. Pointers wrap twice with no corruption.
- Reset mid-frame: write 8'hA5, assert reset during data bit 3 → tx=1 within the same cycle, count=0. After release, no frame is emitted and tx stays 1 for 200000 cycles.
- With UART_TX_PARITY_EN: send 8'h55 → parity bit 0; send 8'h54 → parity bit 1. Frame length is 11*13854 cycles.
